// File: rtl/bk_result_stage_if.sv
// Handshake bundle for bk_result_stage: adder-side push port and
// consumer-side pop port.
interface bk_result_stage_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] sum_in;
   logic [W-1:0] carry_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport slave (
      input  in_valid,
      input  sum_in,
      input  carry_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result,
      output flags
   );

   modport master (
      output in_valid,
      output sum_in,
      output carry_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result,
      input  flags
   );
endinterface

// File: rtl/bk_result_stage.sv
// Registered result stage behind the Brent-Kung adder: flags, 2-deep skid buffer.
// Define SATURATE_EN for signed saturation of the captured result.
module bk_result_stage #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   bk_result_stage_if.slave bus,
   input  logic             clr_sticky,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] res_count
);

   localparam int EW = W + 4;

   logic [EW-1:0]    e0_q, e0_d;
   logic [EW-1:0]    e1_q, e1_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             stk_q, stk_d;
   logic [CNT_W-1:0] rc_q, rc_d;

   logic             c_flag;
   logic             v_flag;
   logic [W-1:0]     res_new;
   logic [EW-1:0]    ent_new;
   logic             push;
   logic             pop;

   assign bus.in_ready  = (cnt_q != 2'd2);
   assign bus.out_valid = (cnt_q != 2'd0);
   assign bus.result    = e0_q[EW-1:4];
   assign bus.flags     = e0_q[3:0];
   assign ovf_sticky    = stk_q;
   assign res_count     = rc_q;

   always_comb begin
      c_flag = bus.carry_in[W-1];
      v_flag = bus.carry_in[W-1] ^ bus.carry_in[W-2];
`ifdef SATURATE_EN
      if (v_flag)
         res_new = c_flag ? {1'b1, {(W-1){1'b0}}}
                          : {1'b0, {(W-1){1'b1}}};
      else
         res_new = bus.sum_in;
`else
      res_new = bus.sum_in;
`endif
      // entry layout: {result, N, Z, C, V}
      ent_new = {res_new, res_new[W-1], (res_new == '0),
                 c_flag, v_flag};
   end

   always_comb begin
      push  = bus.in_valid & bus.in_ready;
      pop   = bus.out_valid & bus.out_ready;
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) e0_d = ent_new;
            else               e1_d = ent_new;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
         end
         // only reachable at count 1: new entry becomes head
         2'b11: e0_d = ent_new;
         default: ;
      endcase
   end

   always_comb begin
      stk_d = stk_q;
      if (pop && e0_q[0]) stk_d = 1'b1;
      else if (clr_sticky) stk_d = 1'b0;
      rc_d = rc_q + CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
         stk_q <= 1'b0;
         rc_q  <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
         stk_q <= stk_d;
         rc_q  <= rc_d;
      end
   end

endmodule

// File: tb/tb_bk_result_stage.sv
// Bench for bk_result_stage: directed steps then random traffic,
// checked against a queue-based model each cycle.
module tb_bk_result_stage;

   localparam int W     = 8;
   localparam int CNT_W = 4;

   typedef struct {
      logic [7:0] res;
      logic [3:0] fl;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr_sticky;
   logic             ovf_sticky;
   logic [CNT_W-1:0] res_count;

   bk_result_stage_if #(.W(W)) bus ();

   bk_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clr_sticky (clr_sticky),
      .ovf_sticky (ovf_sticky),
      .res_count  (res_count)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t q[$];
   int   m_rc  = 0;
   bit   m_stk = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [7:0] s, input logic [7:0] cy);
      ent_t e;
      logic c, v;
      c = cy[7];
      v = cy[7] ^ cy[6];
      e.res = s;
`ifdef SATURATE_EN
      if (v) e.res = c ? 8'h80 : 8'h7F;
`endif
      e.fl = {e.res[7], (e.res == 8'h00), c, v};
      return e;
   endfunction

   // carry out of bit i from the sum of the low i+1 bits of a and b
   task automatic add_vec(input int a, input int b,
                          output logic [7:0] s, output logic [7:0] cy);
      s = 8'((a + b) & 255);
      for (int i = 0; i < 8; i++) begin
         int m;
         m = (1 << (i + 1)) - 1;
         cy[i] = (((a & m) + (b & m)) >> (i + 1)) & 1;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(q.size() != 2));
      chk({tag, ".res_count"}, 32'(res_count), 32'(m_rc));
      chk({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(m_stk));
      if (q.size() != 0) begin
         chk({tag, ".result"}, 32'(bus.result), 32'(q[0].res));
         chk({tag, ".flags"}, 32'(bus.flags), 32'(q[0].fl));
      end
   endtask

   task automatic cyc(input string tag, input bit iv,
                      input logic [7:0] s, input logic [7:0] cy,
                      input bit ordy, input bit clr);
      bit push, pop;
      check_outputs(tag);
      bus.in_valid  = iv;
      bus.sum_in    = s;
      bus.carry_in  = cy;
      bus.out_ready = ordy;
      clr_sticky    = clr;
      push = iv && (q.size() != 2);
      pop  = ordy && (q.size() != 0);
      if (pop && q[0].fl[0]) m_stk = 1'b1;
      else if (clr) m_stk = 1'b0;
      if (pop) begin
         void'(q.pop_front());
         m_rc = (m_rc + 1) % (1 << CNT_W);
      end
      if (push) q.push_back(mk(s, cy));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.sum_in    = 8'h00;
      bus.carry_in  = 8'h00;
      clr_sticky    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_rc  = 0;
      m_stk = 1'b0;
      chk({tag, ".result"}, 32'(bus.result), 32'h0);
      chk({tag, ".flags"}, 32'(bus.flags), 32'h0);
      check_outputs(tag);
   endtask

   initial begin
      logic [7:0] s, cy;
      do_reset("reset");

      cyc("t2_push", 1, 8'h08, 8'h07, 1, 0);
      chk("t2_result", 32'(bus.result), 32'h08);
      chk("t2_flags", 32'(bus.flags), 32'h0);
      cyc("t2_pop", 0, 8'h00, 8'h00, 1, 0);
      chk("t2_count", 32'(res_count), 32'd1);

      cyc("t3_push", 1, 8'h80, 8'h40, 0, 0);
`ifdef SATURATE_EN
      chk("t3_result", 32'(bus.result), 32'h7F);
      chk("t3_flags", 32'(bus.flags), 32'b0001);
`else
      chk("t3_result", 32'(bus.result), 32'h80);
      chk("t3_flags", 32'(bus.flags), 32'b1001);
`endif
      cyc("t3_pop", 0, 8'h00, 8'h00, 1, 0);
      chk("t3_sticky", 32'(ovf_sticky), 32'd1);

      cyc("t4_push", 1, 8'h00, 8'h80, 0, 0);
`ifdef SATURATE_EN
      chk("t4_flags", 32'(bus.flags), 32'b1011);
`else
      chk("t4_flags", 32'(bus.flags), 32'b0111);
`endif
      cyc("t4_pop", 0, 8'h00, 8'h00, 1, 1);
      cyc("t4_clr", 0, 8'h00, 8'h00, 0, 1);
      chk("t4_clr_sticky", 32'(ovf_sticky), 32'd0);

      cyc("t5_p1", 1, 8'h01, 8'h00, 0, 0);
      cyc("t5_p2", 1, 8'h02, 8'h00, 0, 0);
      chk("t5_full", 32'(bus.in_ready), 32'd0);
      cyc("t5_p3", 1, 8'h03, 8'h00, 0, 0);
      cyc("t5_hold", 1, 8'h03, 8'h00, 0, 0);
      chk("t5_head", 32'(bus.result), 32'h01);
      cyc("t5_r1", 1, 8'h03, 8'h00, 1, 0);
      chk("t5_second", 32'(bus.result), 32'h02);
      cyc("t5_r2", 1, 8'h03, 8'h00, 1, 0);
      chk("t5_third", 32'(bus.result), 32'h03);
      cyc("t5_r3", 0, 8'h00, 8'h00, 1, 0);
      chk("t5_empty", 32'(bus.out_valid), 32'd0);

      add_vec(8'h7F, 8'h01, s, cy);
      cyc("t6_push", 1, s, cy, 0, 0);
      cyc("t6_popclr", 0, 8'h00, 8'h00, 1, 1);
      chk("t6_setwins", 32'(ovf_sticky), 32'd1);
      cyc("t6_clr", 0, 8'h00, 8'h00, 0, 1);
      chk("t6_cleared", 32'(ovf_sticky), 32'd0);
      cyc("t6_f1", 1, 8'h11, 8'h00, 0, 0);
      cyc("t6_f2", 1, 8'h22, 8'h00, 0, 0);
      check_outputs("t6_full");
      do_reset("t6_reset");
      cyc("t6_after", 0, 8'h00, 8'h00, 1, 0);

      for (int i = 0; i < 400; i++) begin
         int a, b;
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         add_vec(a, b, s, cy);
         cyc("rand", ($urandom_range(0, 3) != 0), s, cy,
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
      end
      check_outputs("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
